// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: PC stage handshake, instruction memory port, decode-side instruction stream.
// Combinational wires only; no storage and no latency.
// Backpressure is carried by pc_ready (toward PC stage) and instr_ready (from consumer).
interface fetch_unit_if;
  // PC stage side
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        redirect;
  // Instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // Consumer side
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] fetch_pc;
  logic [25:0] jaddr;
  logic [31:0] simm;

  // master: the fetch unit itself
  modport master (
    input  pc, pc_valid, redirect, imem_ack, imem_rdata, instr_ready,
    output pc_ready, imem_req, imem_addr, instr_valid, instr, fetch_pc, jaddr, simm
  );

  // slave: the surrounding pipeline / memory environment
  modport slave (
    output pc, pc_valid, redirect, imem_ack, imem_rdata, instr_ready,
    input  pc_ready, imem_req, imem_addr, instr_valid, instr, fetch_pc, jaddr, simm
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request per accepted pc, results queued in a DEPTH-entry FIFO.
// Latency: pc presented in cycle N, ack in cycle N+1 -> instr_valid from cycle N+2.
// Backpressure: pc_ready drops while a request is in flight, the buffer is full, or redirect is high.
// Ports: clk, reset (async, active-high); bus (fetch_unit_if.master) carries pc/redirect handshake,
//        imem_req/addr/ack/rdata, and instr/fetch_pc/jaddr/simm with instr_valid/instr_ready.
module fetch_unit #(
  parameter int DEPTH = 2  // 2 or 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [PW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic            accept;
  logic            push;
  logic            pop;
  logic            not_empty;
  logic [31:0]     head_instr;

  assign not_empty   = (count_q != '0);
  assign bus.pc_ready = (state_q == IDLE) && (count_q < DEPTH_C) && !bus.redirect;
  assign accept      = bus.pc_valid && bus.pc_ready;
  // A redirect cancels any pop offered in the same cycle; the flush wins.
  assign pop         = not_empty && bus.instr_ready && !bus.redirect;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.pc;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          push    = !bus.redirect;  // ack alongside redirect is stale data
          state_d = IDLE;
        end else if (bus.redirect) begin
          state_d = DROP;            // keep request up, swallow its eventual ack
        end
      end
      DROP: begin
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (bus.redirect) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage contents are only observed through the count gate, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= addr_q;
      ins_mem[wr_q] <= bus.imem_rdata;
    end
  end

  assign head_instr      = not_empty ? ins_mem[rd_q] : 32'h0;
  assign bus.instr       = head_instr;
  assign bus.fetch_pc    = not_empty ? pc_mem[rd_q] : 32'h0;
  assign bus.jaddr       = head_instr[25:0];
  assign bus.simm        = {{16{head_instr[15]}}, head_instr[15:0]};
  assign bus.instr_valid = not_empty;
  assign bus.imem_req    = (state_q != IDLE);
  assign bus.imem_addr   = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Advance one cycle; inputs are driven just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer pc; if accepted, ack after `delay` idle cycles with `rd` and record the expected entry.
  task automatic issue(input logic [31:0] pc, input logic [31:0] rd, input int delay, output logic acc);
    bus.pc       = pc;
    bus.pc_valid = 1'b1;
    #1;
    acc = bus.pc_ready;
    step();
    bus.pc_valid = 1'b0;
    if (acc) begin
      repeat (delay) step();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = rd;
      step();
      bus.imem_ack   = 1'b0;
      sb.push_back('{pc: pc, rd: rd});
    end
  endtask

  task automatic test_reset();
    bus.pc = '0; bus.pc_valid = 1'b0; bus.redirect = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %0h exp 0", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %0h exp 0", bus.instr_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr got %h exp 0", bus.imem_addr); end
    checks++; if (bus.instr !== 32'h0 || bus.fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h/%h exp 0/0", bus.instr, bus.fetch_pc); end
    checks++; if (bus.jaddr !== 26'h0 || bus.simm !== 32'h0) begin errors++; $display("FAIL rst_jaddr_simm got %h/%h exp 0/0", bus.jaddr, bus.simm); end
    reset = 1'b0;
    #1;
    checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL rst_release_pc_ready got %0h exp 1", bus.pc_ready); end
    step();
  endtask

  task automatic test_basic();
    exp_t e;
    bus.pc = 32'd5; bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd5) begin errors++; $display("FAIL basic_req got req=%0h addr=%h exp 1/5", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_pc_ready got %0h exp 0", bus.pc_ready); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0800_0010;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0h exp 0", bus.instr_valid); end
    sb.push_back('{pc: 32'd5, rd: 32'h0800_0010});
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL basic_valid got v=%0h req=%0h exp 1/0", bus.instr_valid, bus.imem_req); end
    checks++; if (bus.jaddr !== 26'h000_0010 || bus.simm !== 32'h0000_0010) begin errors++; $display("FAIL basic_decode got %h/%h exp 0000010/00000010", bus.jaddr, bus.simm); end
    e = sb.pop_front();
    checks++; if (bus.fetch_pc !== e.pc || bus.instr !== e.rd) begin errors++; $display("FAIL basic_head got %h/%h exp %h/%h", bus.fetch_pc, bus.instr, e.pc, e.rd); end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %0h exp 0", bus.instr_valid); end
    step();
  endtask

  task automatic test_simm();
    logic acc;
    exp_t e;
    issue(32'd9, 32'h1000_FFFE, 0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL simm_accept got %0h exp 1", acc); end
    #1;
    checks++; if (bus.simm !== 32'hFFFF_FFFE || bus.jaddr !== 26'h000_FFFE) begin errors++; $display("FAIL simm_neg got %h/%h exp FFFFFFFE/000FFFE", bus.simm, bus.jaddr); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (bus.fetch_pc !== e.pc || bus.instr !== e.rd) begin errors++; $display("FAIL simm_head got %h/%h exp %h/%h", bus.fetch_pc, bus.instr, e.pc, e.rd); end
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic acc;
    exp_t e;
    bus.instr_ready = 1'b0;
    issue(32'd1, 32'hA000_0001, 0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept1 got %0h exp 1", acc); end
    issue(32'd2, 32'hB000_8002, 1, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept2 got %0h exp 1", acc); end
    bus.pc = 32'd3; bus.pc_valid = 1'b1;
    #1;
    checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_pc_ready got %0h exp 0", bus.pc_ready); end
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_no_req got %0h exp 0", bus.imem_req); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (bus.fetch_pc !== e.pc || bus.instr !== e.rd) begin errors++; $display("FAIL bp_head1 got %h/%h exp %h/%h", bus.fetch_pc, bus.instr, e.pc, e.rd); end
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    #1;
    checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_pc_ready got %0h exp 1", bus.pc_ready); end
    issue(32'd3, 32'hC3FF_7003, 0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept3 got %0h exp 1", acc); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      checks++; if (bus.instr_valid !== 1'b1 || bus.fetch_pc !== e.pc || bus.instr !== e.rd) begin errors++; $display("FAIL bp_order got v=%0h %h/%h exp %h/%h", bus.instr_valid, bus.fetch_pc, bus.instr, e.pc, e.rd); end
      checks++; if (bus.jaddr !== e.rd[25:0] || bus.simm !== {{16{e.rd[15]}}, e.rd[15:0]}) begin errors++; $display("FAIL bp_decode got %h/%h exp %h/%h", bus.jaddr, bus.simm, e.rd[25:0], {{16{e.rd[15]}}, e.rd[15:0]}); end
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
    end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0h exp 0", bus.instr_valid); end
  endtask

  task automatic test_redirect_drop();
    bus.pc = 32'd7; bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    bus.redirect = 1'b1;
    #1;
    checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL drop_redirect_pc_ready got %0h exp 0", bus.pc_ready); end
    step();
    bus.redirect = 1'b0;
    repeat (2) step();
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd7) begin errors++; $display("FAIL drop_req_held got req=%0h addr=%h exp 1/7", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL drop_pc_ready got %0h exp 0", bus.pc_ready); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL drop_discard got req=%0h v=%0h exp 0/0", bus.imem_req, bus.instr_valid); end
    checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL drop_idle_pc_ready got %0h exp 1", bus.pc_ready); end
    // redirect and ack in the same cycle: data dropped, straight back to idle
    bus.pc = 32'd8; bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    bus.redirect = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    step();
    bus.redirect = 1'b0; bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_ack got req=%0h v=%0h exp 0/0", bus.imem_req, bus.instr_valid); end
    step();
  endtask

  task automatic test_flush_full();
    logic acc;
    exp_t e;
    issue(32'd10, 32'h0000_000A, 0, acc);
    issue(32'd11, 32'h0000_000B, 0, acc);
    #1;
    checks++; if (bus.pc_ready !== 1'b0 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL flush_full got rdy=%0h v=%0h exp 0/1", bus.pc_ready, bus.instr_valid); end
    bus.redirect = 1'b1; bus.instr_ready = 1'b1;
    step();
    bus.redirect = 1'b0; bus.instr_ready = 1'b0;
    sb.delete();
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%0h rdy=%0h exp 0/1", bus.instr_valid, bus.pc_ready); end
    issue(32'd12, 32'h0000_800C, 0, acc);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (bus.fetch_pc !== e.pc || bus.instr !== e.rd) begin errors++; $display("FAIL flush_refill got %h/%h exp %h/%h", bus.fetch_pc, bus.instr, e.pc, e.rd); end
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_count got %0h exp 0", bus.instr_valid); end
    step();
  endtask

  task automatic test_async_reset();
    logic acc;
    issue(32'd19, 32'h0000_0013, 0, acc);
    bus.pc = 32'd20; bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got req=%0h v=%0h exp 1/1", bus.imem_req, bus.instr_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL areset_now got req=%0h v=%0h exp 0/0", bus.imem_req, bus.instr_valid); end
    checks++; if (bus.imem_addr !== 32'h0 || bus.fetch_pc !== 32'h0) begin errors++; $display("FAIL areset_regs got %h/%h exp 0/0", bus.imem_addr, bus.fetch_pc); end
    reset = 1'b0;
    sb.delete();
    // late ack for the abandoned request must be ignored
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    step();
    bus.imem_ack = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_ready !== 1'b1) begin errors++; $display("FAIL areset_stale_ack got v=%0h rdy=%0h exp 0/1", bus.instr_valid, bus.pc_ready); end
    step();
  endtask

  task automatic test_back_to_back();
    logic acc;
    exp_t e;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(32'd100 + 32'(i), $urandom, $urandom_range(0, 2), acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got %0h exp 1", i, acc); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.fetch_pc !== e.pc || bus.instr !== e.rd) begin errors++; $display("FAIL b2b_head%0d got v=%0h %h/%h exp %h/%h", i, bus.instr_valid, bus.fetch_pc, bus.instr, e.pc, e.rd); end
      end
    end
    step();
    bus.instr_ready = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0h exp 0", bus.instr_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simm();
    test_backpressure();
    test_redirect_drop();
    test_flush_full();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc  input  32  word index of next instruction, from program counter stage.
REQ-005 pc_valid  input  1  pc is valid this cycle.
REQ-006 pc_ready  output  1  fetch_unit accepts pc this cycle; PC stage advances only when pc_valid && pc_ready.
REQ-007 redirect  input  1  branch/jump taken; flush all in-flight and buffered instructions.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  word address to instruction memory.
REQ-010 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr_valid  output  1  buffer head holds a valid instruction.
REQ-013 instr_ready  input  1  consumer pops head when instr_valid && instr_ready.
REQ-014 instr  output  32  head instruction word.
REQ-015 fetch_pc  output  32  word index of head instruction.
REQ-016 jaddr  output  26  instr[25:0], jump target for PC stage.
REQ-017 simm  output  32  instr[15:0] sign-extended, branch offset for PC stage.

Function
REQ-018 FSM states: IDLE, REQ, DROP; IDLE after reset.
REQ-019 pc_ready = (state==IDLE) && (count < DEPTH) && !redirect, combinational.
REQ-020 IDLE, pc_valid && pc_ready: imem_addr <= pc, state <= REQ; otherwise hold IDLE.
REQ-021 REQ: imem_req=1, imem_addr stable until imem_ack; imem_ack without redirect: push {imem_addr, imem_rdata}, state <= IDLE.
REQ-022 REQ with redirect, no imem_ack: state <= DROP; imem_req held high.
REQ-023 REQ with redirect and imem_ack same cycle: data discarded, state <= IDLE.
REQ-024 DROP: imem_req=1 until imem_ack; data discarded, state <= IDLE; redirect in DROP has no additional effect.
REQ-025 imem_req=0 in IDLE; at most one outstanding memory request.
REQ-026 Buffer: circular FIFO, DEPTH entries, rd/wr pointers wrap modulo DEPTH, count 0..DEPTH.
REQ-027 Push never overflows: request issued only when count < DEPTH, no other push source.
REQ-028 Push and pop same cycle: both performed, count unchanged.
REQ-029 Pop with count==0 impossible; instr_valid = (count != 0).
REQ-030 redirect: next edge sets count=0, rd=wr=0; any same-cycle push/pop ignored.
REQ-031 Count 0: instr, fetch_pc driven 0; jaddr, simm derived from instr.
REQ-032 Latency: pc accepted at edge N -> earliest instr_valid at edge N+2 with one-cycle ack (N+1 REQ, ack, N+2 visible).
REQ-033 Addresses unsigned 32-bit; no increment arithmetic, pc passed through unchanged.

Reset
REQ-034 reset asserted: immediately state=IDLE, count=0, pointers 0, imem_addr=0, imem_req=0, instr_valid=0, instr=0, fetch_pc=0, jaddr=0, simm=0.
REQ-035 Reset mid-REQ/DROP: request abandoned; fetch_unit ignores imem_ack until a new request is issued.
REQ-036 Reset release: pc_ready=1 in first cycle after release.

Verification
REQ-037 pc=5 accepted, ack next cycle with rdata=0x08000010 -> instr_valid=1, fetch_pc=5, jaddr=0x0000010, simm=0x00000010.
REQ-038 rdata=0x1000FFFE -> simm=0xFFFFFFFE, jaddr=0x000FFFE.
REQ-039 instr_ready=0, pcs 1,2,3 offered, DEPTH=2 -> two accepted, pc_ready=0 at count 2; pop -> pc_ready=1, pc 3 fetched, order 1,2,3.
REQ-040 redirect in REQ, ack delayed 3 cycles -> DROP, imem_req held, data discarded, instr_valid=0, IDLE after ack.
REQ-041 Full buffer, redirect and instr_ready same cycle -> count=0 next cycle, no pop counted, pc_ready=1.
REQ-042 Async reset mid-REQ between edges -> imem_req=0 and instr_valid=0 immediately, before next clk edge.
